col_parity_theta_engine: RTL and testbench

Parametrised sequential column-parity engine for the encoder's 5x5xDEPTH state. It accepts one 25-bit slice per handshake and builds a 5-bit column-parity vector per slice in an internal buffer. After a full frame of DEPTH slices it streams one 5-bit theta-effect vector per slice, including the wrap-around term from slice DEPTH-1 into slice 0. It supersedes the single-slice, next-column parity helper in the column-parity path.

---
 rtl/col_parity_pkg.sv | 18 +
 rtl/col_parity_slice.sv | 18 +
 rtl/col_parity_theta_engine.sv | 129 ++++++++++++
 tb/tb_col_parity_theta_engine.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/col_parity_pkg.sv
// Shared constants, FSM state type and lane addressing for the column-parity engine.
package col_parity_pkg;

    localparam int LANES = 25;
    localparam int COLS  = 5;
    localparam int ROWS  = 5;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Lane (x,y) of a 25-bit slice lives at bit 24-(5y+x).
    function automatic int lane_bit(input int x, input int y);
        return (LANES - 1) - (COLS * y + x);
    endfunction

endpackage

// File: rtl/col_parity_slice.sv
// Combinational column parity of one 25-bit slice; column x lands on bit 4-x.
module col_parity_slice
    import col_parity_pkg::*;
(
    input  logic [LANES-1:0] slice,
    output logic [COLS-1:0]  par
);

    always_comb begin
        par = '0;
        for (int x = 0; x < COLS; x++) begin
            for (int y = 0; y < ROWS; y++) begin
                par[COLS-1-x] = par[COLS-1-x] ^ slice[lane_bit(x, y)];
            end
        end
    end

endmodule

// File: rtl/col_parity_theta_engine.sv
// Frame-based column-parity / theta-effect engine: loads DEPTH slices, then streams one result per slice.
// Define COL_PARITY_THETA_EN to emit the theta mix D; otherwise the raw column parity C is emitted.
module col_parity_theta_engine
    import col_parity_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDXW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] in_slice,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [COLS-1:0]  out_par,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             busy
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never drops and its payload never changes until that transfer takes place.

    state_e          state;
    state_e          state_nxt;
    logic [IDXW-1:0] cnt;
    logic [IDXW-1:0] cnt_nxt;
    logic [COLS-1:0] par_buf [DEPTH];
    logic [COLS-1:0] c_in;
    logic [COLS-1:0] mix;
    logic            in_fire;
    logic            out_fire;

    col_parity_slice u_slice (
        .slice (in_slice),
        .par   (c_in)
    );

    assign in_ready  = rst && (state == LOAD);
    assign out_valid = rst && (state == EMIT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LOAD;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The buffer is deliberately not reset: every frame rewrites all DEPTH entries before EMIT.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            par_buf[cnt] <= c_in;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            LOAD: begin
                if (in_fire) begin
                    if (cnt == LAST_IDX) begin
                        state_nxt = EMIT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_fire) begin
                    if (cnt == LAST_IDX) begin
                        state_nxt = LOAD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = LOAD;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef COL_PARITY_THETA_EN
    logic [IDXW-1:0] z_prev;
    logic [COLS-1:0] cur_par;
    logic [COLS-1:0] prev_par;

    // Slice 0 pairs with slice DEPTH-1: the wrap-around term.
    assign z_prev   = (cnt == '0) ? LAST_IDX : cnt - 1'b1;
    assign cur_par  = par_buf[cnt];
    assign prev_par = par_buf[z_prev];

    always_comb begin
        mix = '0;
        for (int x = 0; x < COLS; x++) begin
            mix[COLS-1-x] = cur_par[COLS-1-((x + 4) % COLS)]
                          ^ prev_par[COLS-1-((x + 1) % COLS)];
        end
    end
`else
    assign mix = par_buf[cnt];
`endif

    always_comb begin
        out_par  = '0;
        out_idx  = '0;
        out_last = 1'b0;
        if (out_valid) begin
            out_par  = mix;
            out_idx  = cnt;
            out_last = (cnt == LAST_IDX);
        end
    end

    assign busy = rst && ((state == EMIT) || (cnt != '0));

endmodule

// File: tb/tb_col_parity_theta_engine.sv
// Self-checking bench for col_parity_theta_engine at DEPTH=4 with a scoreboard of expected outputs.
module tb_col_parity_theta_engine;

    localparam int DEPTH = 4;
    localparam int IDXW  = $clog2(DEPTH);
    localparam int EW    = 1 + IDXW + 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [24:0]     in_slice;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_par;
    logic [IDXW-1:0] out_idx;
    logic            out_last;
    logic            busy;

    logic [EW-1:0]   exp_q[$];
    logic [24:0]     frame [DEPTH];
    logic [4:0]      got_par [DEPTH];
    int              n_check = 0;
    int              n_pass  = 0;

    col_parity_theta_engine #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_slice  (in_slice),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_par   (out_par),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_check++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [4:0] col_par(input logic [24:0] s);
        logic [4:0] r;
        r = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[4-x] = r[4-x] ^ s[24-(5*y+x)];
        return r;
    endfunction

    task automatic push_expected();
        logic [4:0] c [DEPTH];
        logic [4:0] e;
        for (int z = 0; z < DEPTH; z++) c[z] = col_par(frame[z]);
        for (int z = 0; z < DEPTH; z++) begin
`ifdef COL_PARITY_THETA_EN
            for (int x = 0; x < 5; x++)
                e[4-x] = c[z][4-((x+4)%5)] ^ c[(z+DEPTH-1)%DEPTH][4-((x+1)%5)];
`else
            e = c[z];
`endif
            exp_q.push_back({(z == DEPTH-1), IDXW'(z), e});
        end
    endtask

    task automatic load_slices(input int n);
        int w;
        for (int z = 0; z < n; z++) begin
            in_valid = 1'b1;
            in_slice = frame[z];
            w = 0;
            @(negedge clk);
            while (!in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) check("in_ready_timeout", 32'(0), 32'(1));
            @(posedge clk);
            #1;
            check("busy_after_in", 32'(busy), 32'(1));
        end
        in_valid = 1'b0;
        in_slice = 25'($urandom);
    endtask

    task automatic load_frame();
        load_slices(DEPTH);
        push_expected();
        check("latency_out_valid", 32'(out_valid), 32'(1));
        check("emit_in_ready", 32'(in_ready), 32'(0));
    endtask

    task automatic drain(input int stall_idx, input int stall_n);
        int n;
        int stalls;
        logic [4:0]      hold_par;
        logic [IDXW-1:0] hold_idx;
        logic [EW-1:0]   e;
        n = 0;
        stalls = 0;
        hold_par = '0;
        hold_idx = '0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
            if (out_valid) begin
                if (int'(out_idx) == stall_idx && stalls < stall_n) begin
                    if (stalls == 0) begin
                        hold_par = out_par;
                        hold_idx = out_idx;
                    end else begin
                        check("stall_par_stable", 32'(out_par), 32'(hold_par));
                        check("stall_idx_stable", 32'(out_idx), 32'(hold_idx));
                    end
                    check("stall_in_ready", 32'(in_ready), 32'(0));
                    stalls++;
                    out_ready = 1'b0;
                end else begin
                    if (stall_n > 0 && stalls == stall_n && int'(out_idx) == stall_idx)
                        check("stall_release_par", 32'(out_par), 32'(hold_par));
                    out_ready = 1'b1;
                    e = exp_q.pop_front();
                    check("out_beat", 32'({out_last, out_idx, out_par}), 32'(e));
                    got_par[out_idx] = out_par;
                end
            end else begin
                out_ready = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        if (n >= 200) check("drain_timeout", 32'(exp_q.size()), 32'(0));
        check("idle_out_valid", 32'(out_valid), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_in_ready", 32'(in_ready), 32'(1));
    endtask

    task automatic set_frame(input logic [24:0] s0, input logic [24:0] s1,
                             input logic [24:0] s2, input logic [24:0] s3);
        frame[0] = s0;
        frame[1] = s1;
        frame[2] = s2;
        frame[3] = s3;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_slice  = '0;
        out_ready = 1'b0;
        for (int z = 0; z < DEPTH; z++) got_par[z] = '0;

        // Reset behaviour
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_out_par", 32'(out_par), 32'(0));
        check("rst_out_idx", 32'(out_idx), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'(1));
        check("post_rst_busy", 32'(busy), 32'(0));

        // All-zero frame
        set_frame(25'h0, 25'h0, 25'h0, 25'h0);
        load_frame();
        drain(-1, 0);
        for (int z = 0; z < DEPTH; z++) check("zero_frame", 32'(got_par[z]), 32'(0));

        // Single lane (0,0) set in slice 0
        set_frame(25'h1000000, 25'h0, 25'h0, 25'h0);
        load_frame();
        drain(-1, 0);
`ifdef COL_PARITY_THETA_EN
        check("lane00_z0", 32'(got_par[0]), 32'(5'b01000));
        check("lane00_z1", 32'(got_par[1]), 32'(5'b00001));
`else
        check("lane00_z0", 32'(got_par[0]), 32'(5'b10000));
        check("lane00_z1", 32'(got_par[1]), 32'(5'b00000));
`endif
        check("lane00_z2", 32'(got_par[2]), 32'(5'b00000));
        check("lane00_z3", 32'(got_par[3]), 32'(5'b00000));

        // Single lane in the last slice exercises the wrap-around term
        set_frame(25'h0, 25'h0, 25'h0, 25'h1000000);
        load_frame();
        drain(-1, 0);
`ifdef COL_PARITY_THETA_EN
        check("wrap_z3", 32'(got_par[3]), 32'(5'b01000));
        check("wrap_z0", 32'(got_par[0]), 32'(5'b00001));
`else
        check("wrap_z3", 32'(got_par[3]), 32'(5'b10000));
        check("wrap_z0", 32'(got_par[0]), 32'(5'b00000));
`endif
        check("wrap_z1", 32'(got_par[1]), 32'(5'b00000));

        // Column 0 with four rows set has even parity, so everything cancels
        set_frame(25'h1084200, 25'h0, 25'h0, 25'h0);
        load_frame();
        drain(-1, 0);
        for (int z = 0; z < DEPTH; z++) check("even_column", 32'(got_par[z]), 32'(0));

        // Backpressure at idx 1 for 3 cycles, with a slice waiting upstream
        set_frame(25'($urandom), 25'($urandom), 25'($urandom), 25'($urandom));
        load_frame();
        in_valid = 1'b1;
        in_slice = 25'h1ffffff;
        drain(1, 3);
        in_valid = 1'b0;

        // Reset after two input handshakes discards the partial frame
        set_frame(25'h1ffffff, 25'h0aaaaaa, 25'h0, 25'h0);
        load_slices(2);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("after_midrst_in_ready", 32'(in_ready), 32'(1));
        check("after_midrst_busy", 32'(busy), 32'(0));
        set_frame(25'h0, 25'h1000000, 25'h0, 25'h0);
        load_frame();
        drain(-1, 0);
`ifdef COL_PARITY_THETA_EN
        check("fresh_z1", 32'(got_par[1]), 32'(5'b01000));
        check("fresh_z2", 32'(got_par[2]), 32'(5'b00001));
`else
        check("fresh_z1", 32'(got_par[1]), 32'(5'b10000));
        check("fresh_z2", 32'(got_par[2]), 32'(5'b00000));
`endif
        check("fresh_z0", 32'(got_par[0]), 32'(5'b00000));

        // Random frames with random stalls
        for (int f = 0; f < 6; f++) begin
            for (int z = 0; z < DEPTH; z++) frame[z] = 25'($urandom);
            load_frame();
            drain($urandom_range(0, DEPTH-1), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
